// File: rtl/pipeline_pkg.sv
// Shared encodings for the LEGv8 pipeline sequencer: FSM states, forwarding
// selects and the zero-register address.
package pipeline_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int XZR = 31;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one ALU operand; EX/MEM wins over MEM/WB
// and XZR is never forwarded.
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(XZR);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != ZR) && (mem_rd == src);
  assign wb_hit  = wb_regwrite  && (wb_rd  != ZR) && (wb_rd  == src);

  always_comb begin
    if (mem_hit)     sel = FWD_EXMEM;
    else if (wb_hit) sel = FWD_MEMWB;
    else             sel = FWD_REG;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX sequencer: load-use stall/bubble, taken-branch flush and forwarding.
// Optional perf counters (stall_cnt, flush_cnt) when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_uses_rm,
  input  logic [REG_AW-1:0] ex_rn,
  input  logic [REG_AW-1:0] ex_rm,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_br_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stalled
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [REG_AW-1:0] ZR         = REG_AW'(XZR);
  localparam logic [2:0]        STALL_INIT = 3'(STALL_CYC - 1);

  state_e     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hz;
  logic       flush;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // NOTE: reset is sampled on the clock edge, and registers use <= so every
  // flop sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign hz = ex_memread && (ex_rd != ZR) &&
              ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  // NOTE: every output and next-state term gets a default first so no latch
  // can be inferred from the branches below.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;

    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush       = 1'b1;
      state_nxt   = ST_RUN;
      cnt_nxt     = '0;
    end else if (mem_br_taken) begin
      // A taken branch squashes whatever the hazard logic wanted this cycle.
      flush     = 1'b1;
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (STALL_CYC > 1) begin
              state_nxt = ST_STALL;
              cnt_nxt   = STALL_INIT;
            end
          end
        end
        ST_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_nxt      = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign flush_if_id  = flush;
  assign flush_id_ex  = flush;
  assign flush_ex_mem = flush;
  assign stalled      = (state == ST_STALL);

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (ex_rn),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (fwd_a_raw)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (ex_rm),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (fwd_b_raw)
  );

  assign fwd_a = rst_n ? fwd_a_raw : FWD_REG;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_ex_bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (mem_br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
